// File: rtl/dq_seq_pkg.sv
// dq_seq_pkg: shared encodings for the DQ-form quadword load/store sequencer.
package dq_seq_pkg;
    localparam logic [1:0] OP_LQ   = 2'd0;
    localparam logic [1:0] OP_LXV  = 2'd1;
    localparam logic [1:0] OP_STXV = 2'd2;
    localparam int BEAT_OFFSET = 8;
    localparam logic WB_GPR = 1'b0;
    localparam logic WB_VSR = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_WAIT,
        S_WB,
        S_DONE,
        S_FAULT
    } state_t;
endpackage

// File: rtl/dq_ea_adder.sv
// dq_ea_adder: DQ-form effective address base + sext(imm << 4) and the second-beat address.
// DQ_SEQ_ALIGN_CHECK_EN enables the 16-byte misalignment flag; otherwise the flag reads 0.
module dq_ea_adder
    import dq_seq_pkg::*;
#(
    parameter int immWidth  = 12,
    parameter int addrWidth = 64
) (
    input  logic [immWidth-1:0]  imm,
    input  logic [addrWidth-1:0] base,
    output logic [addrWidth-1:0] ea,
    output logic [addrWidth-1:0] ea_next,
    output logic                 misaligned
);
    assign ea = base + {{(addrWidth-immWidth-4){imm[immWidth-1]}}, imm, 4'b0000};
    assign ea_next = ea + addrWidth'(BEAT_OFFSET);
`ifdef DQ_SEQ_ALIGN_CHECK_EN
    assign misaligned = |ea[3:0];
`else
    assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/dq_lsu_sequencer.sv
// dq_lsu_sequencer: splits DQ-form LQ/LXV/STXV ops into two doubleword beats on a 64-bit memory port.
// Define DQ_SEQ_ALIGN_CHECK_EN to fault EAs that are not 16-byte aligned.
module dq_lsu_sequencer
    import dq_seq_pkg::*;
#(
    parameter int regWidth  = 5,
    parameter int immWidth  = 12,
    parameter int addrWidth = 64,
    parameter int dataWidth = 64
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic [1:0]             opKind_i,
    input  logic [regWidth-1:0]    reg1_i,
    input  logic                   bit_i,
    input  logic [regWidth-1:0]    reg2_i,
    input  logic [immWidth-1:0]    imm_i,
    input  logic [addrWidth-1:0]   baseAddr_i,
    input  logic [2*dataWidth-1:0] storeData_i,
    output logic                   stall_o,
    output logic                   memReq_o,
    input  logic                   memReady_i,
    output logic                   memWe_o,
    output logic [addrWidth-1:0]   memAddr_o,
    output logic [dataWidth-1:0]   memWdata_o,
    input  logic                   memRvalid_i,
    input  logic [dataWidth-1:0]   memRdata_i,
    output logic                   wbEnable_o,
    output logic                   wbFile_o,
    output logic [regWidth:0]      wbReg_o,
    output logic [2*dataWidth-1:0] wbData_o,
    output logic                   done_o,
    output logic                   fault_o
);
    state_t state, state_n;
    logic [1:0] kind_q, cnt_q, cnt_n;
    logic [regWidth:0] reg_q;
    logic [addrWidth-1:0] ea, ea_next, ea_next_q;
    logic [dataWidth-1:0] sdata_lo_q, hi_q, lo_q, hi_n, lo_n;
    logic misaligned, illegal, take_rsp;

    dq_ea_adder #(.immWidth(immWidth), .addrWidth(addrWidth)) u_ea (
        .imm(imm_i),
        .base(baseAddr_i),
        .ea(ea),
        .ea_next(ea_next),
        .misaligned(misaligned)
    );

    always_comb begin
        illegal = (opKind_i != OP_LQ && opKind_i != OP_LXV && opKind_i != OP_STXV)
                  || (opKind_i == OP_LQ && (reg1_i[0] || reg1_i == reg2_i)) || misaligned;
        // read data is only meaningful for loads between the two requests and writeback
        take_rsp = memRvalid_i && (state == S_REQ1 || state == S_WAIT) && kind_q != OP_STXV;
        cnt_n = cnt_q + {1'b0, take_rsp};
        hi_n = (take_rsp && cnt_q == 2'd0) ? memRdata_i : hi_q;
        lo_n = (take_rsp && cnt_q == 2'd1) ? memRdata_i : lo_q;
        state_n = state;
        case (state)
            S_IDLE:  state_n = enable_i ? (illegal ? S_FAULT : S_REQ0) : S_IDLE;
            S_REQ0:  state_n = memReady_i ? S_REQ1 : S_REQ0;
            S_REQ1:  state_n = memReady_i ? (kind_q == OP_STXV ? S_DONE : S_WAIT) : S_REQ1;
            S_WAIT:  state_n = (cnt_n == 2'd2) ? S_WB : S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= S_IDLE;
            kind_q     <= '0;
            cnt_q      <= '0;
            reg_q      <= '0;
            ea_next_q  <= '0;
            sdata_lo_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            stall_o    <= 1'b0;
            memReq_o   <= 1'b0;
            memWe_o    <= 1'b0;
            memAddr_o  <= '0;
            memWdata_o <= '0;
            wbEnable_o <= 1'b0;
            wbFile_o   <= 1'b0;
            wbReg_o    <= '0;
            wbData_o   <= '0;
            done_o     <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt_q      <= (state_n == S_IDLE) ? 2'd0 : cnt_n;
            hi_q       <= hi_n;
            lo_q       <= lo_n;
            stall_o    <= state_n != S_IDLE;
            memReq_o   <= state_n == S_REQ0 || state_n == S_REQ1;
            done_o     <= state_n == S_WB || state_n == S_DONE;
            wbEnable_o <= state_n == S_WB;
            fault_o    <= state_n == S_FAULT;
            if (state == S_IDLE) begin
                kind_q     <= opKind_i;
                reg_q      <= {bit_i, reg1_i};
                ea_next_q  <= ea_next;
                sdata_lo_q <= storeData_i[dataWidth-1:0];
            end
            if (state == S_IDLE && state_n == S_REQ0) begin
                memAddr_o  <= ea;
                memWdata_o <= storeData_i[2*dataWidth-1:dataWidth];
                memWe_o    <= opKind_i == OP_STXV;
            end
            if (state == S_REQ0 && memReady_i) begin
                memAddr_o  <= ea_next_q;
                memWdata_o <= sdata_lo_q;
            end
            if (state == S_REQ1 && memReady_i)
                memWe_o <= 1'b0;
            if (state_n == S_WB) begin
                wbData_o <= {hi_n, lo_n};
                wbReg_o  <= (kind_q == OP_LQ) ? {1'b0, reg_q[regWidth-1:0]} : reg_q;
                wbFile_o <= (kind_q == OP_LQ) ? WB_GPR : WB_VSR;
            end
        end
    end
endmodule

// File: tb/tb_dq_lsu_sequencer.sv
// tb_dq_lsu_sequencer: directed stimulus with a request/event/writeback scoreboard checked by a monitor.
module tb_dq_lsu_sequencer;
    logic         clock_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         enable_i = 1'b0;
    logic [1:0]   opKind_i = '0;
    logic [4:0]   reg1_i = '0;
    logic         bit_i = 1'b0;
    logic [4:0]   reg2_i = '0;
    logic [11:0]  imm_i = '0;
    logic [63:0]  baseAddr_i = '0;
    logic [127:0] storeData_i = '0;
    logic         stall_o, memReq_o, memWe_o, wbEnable_o, wbFile_o, done_o, fault_o;
    logic         memReady_i = 1'b1;
    logic         memRvalid_i = 1'b0;
    logic [63:0]  memAddr_o, memWdata_o;
    logic [63:0]  memRdata_i = '0;
    logic [5:0]   wbReg_o;
    logic [127:0] wbData_o;

    dq_lsu_sequencer dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .opKind_i(opKind_i),
        .reg1_i(reg1_i), .bit_i(bit_i), .reg2_i(reg2_i), .imm_i(imm_i), .baseAddr_i(baseAddr_i),
        .storeData_i(storeData_i), .stall_o(stall_o), .memReq_o(memReq_o), .memReady_i(memReady_i),
        .memWe_o(memWe_o), .memAddr_o(memAddr_o), .memWdata_o(memWdata_o), .memRvalid_i(memRvalid_i),
        .memRdata_i(memRdata_i), .wbEnable_o(wbEnable_o), .wbFile_o(wbFile_o), .wbReg_o(wbReg_o),
        .wbData_o(wbData_o), .done_o(done_o), .fault_o(fault_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {logic [63:0] addr; logic we; logic [63:0] data;} req_t;
    typedef struct {int kind; int cyc;} evt_t;
    typedef struct {logic [127:0] data; logic [5:0] rg; logic file;} wb_t;
    localparam int E_DONE = 0, E_WB = 1, E_FAULT = 2;

    req_t req_q[$];
    evt_t evt_q[$];
    wb_t  wb_q[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic hold_prev = 1'b0, hold_we = 1'b0;
    logic [63:0] hold_addr = '0, hold_data = '0;

    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic exp_req(input logic [63:0] a, input logic w, input logic [63:0] d);
        req_t r;
        r.addr = a; r.we = w; r.data = d;
        req_q.push_back(r);
    endtask

    task automatic exp_evt(input int k, input int c);
        evt_t e;
        e.kind = k; e.cyc = c;
        evt_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [127:0] d, input logic [5:0] rg, input logic f);
        wb_t w;
        w.data = d; w.rg = rg; w.file = f;
        wb_q.push_back(w);
    endtask

    task automatic issue(input logic [1:0] k, input logic [4:0] r1, input logic b, input logic [4:0] r2,
                         input logic [11:0] im, input logic [63:0] base, input logic [127:0] sd,
                         output int c0);
        enable_i = 1'b1; opKind_i = k; reg1_i = r1; bit_i = b; reg2_i = r2;
        imm_i = im; baseAddr_i = base; storeData_i = sd;
        c0 = cyc;
        step(1);
        enable_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_req"}, memReq_o, 0);
        chk({tag, "_we"}, memWe_o, 0);
        chk({tag, "_addr"}, memAddr_o, 0);
        chk({tag, "_wdata"}, memWdata_o, 0);
        chk({tag, "_wben"}, wbEnable_o, 0);
        chk({tag, "_wbfile"}, wbFile_o, 0);
        chk({tag, "_wbreg"}, wbReg_o, 0);
        chk({tag, "_wbdata"}, wbData_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_fault"}, fault_o, 0);
    endtask

    // Monitor: every accepted request, completion pulse and writeback is matched against the queues.
    always @(negedge clock_i) begin : monitor
        req_t r;
        evt_t e;
        wb_t  w;
        if (memReq_o && memReady_i) begin
            if (req_q.size() == 0) chk("unexpected_req_addr", memAddr_o, 0 ^ ~memAddr_o);
            else begin
                r = req_q.pop_front();
                chk("req_addr", memAddr_o, r.addr);
                chk("req_we", memWe_o, r.we);
                if (r.we) chk("req_wdata", memWdata_o, r.data);
            end
        end
        if (hold_prev) begin
            chk("hold_req", memReq_o, 1);
            chk("hold_addr", memAddr_o, hold_addr);
            chk("hold_we", memWe_o, hold_we);
            chk("hold_wdata", memWdata_o, hold_data);
        end
        hold_prev <= memReq_o && !memReady_i;
        hold_addr <= memAddr_o;
        hold_we   <= memWe_o;
        hold_data <= memWdata_o;
        if (done_o || fault_o) begin
            if (evt_q.size() == 0) chk("unexpected_evt", {done_o, fault_o}, 0);
            else begin
                e = evt_q.pop_front();
                chk("evt_kind", fault_o ? E_FAULT : (wbEnable_o ? E_WB : E_DONE), e.kind);
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_excl", done_o && fault_o, 0);
            end
        end
        if (wbEnable_o) begin
            if (wb_q.size() == 0) chk("unexpected_wb", wbEnable_o, 0);
            else begin
                w = wb_q.pop_front();
                chk("wb_data", wbData_o, w.data);
                chk("wb_reg", wbReg_o, w.rg);
                chk("wb_file", wbFile_o, w.file);
            end
        end
    end

    initial begin
        int c0;
        #3;
        check_zero("reset");
        step(2);
        reset_n_i = 1'b1;
        step(1);

        // STXV store, ready tied high
        issue(2'd2, 5'd0, 1'b0, 5'd0, 12'h001, 64'h1000,
              {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, c0);
        exp_req(64'h1010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        exp_req(64'h1018, 1'b1, 64'h5555_5555_5555_5555);
        exp_evt(E_DONE, c0 + 3);
        for (int i = 1; i <= 3; i++) begin
            chk("store_stall", stall_o, 1);
            step(1);
        end
        chk("store_idle", stall_o, 0);

        // LXV load, XT = {1,3}, imm = -16, zero-gap responses
        issue(2'd1, 5'd3, 1'b1, 5'd0, 12'hFFF, 64'h2000, 128'h0, c0);
        exp_req(64'h1FF0, 1'b0, 64'h0);
        exp_req(64'h1FF8, 1'b0, 64'h0);
        exp_evt(E_WB, c0 + 4);
        exp_wb({64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 6'd35, 1'b1);
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'h1111_1111_1111_1111;
        step(1);
        memRdata_i = 64'h2222_2222_2222_2222;
        step(1);
        memRvalid_i = 1'b0;
        step(1);

        // back-pressure: ready low for cycles 1..3 while in REQ0
        memReady_i = 1'b0;
        issue(2'd2, 5'd0, 1'b0, 5'd0, 12'h000, 64'h3000,
              {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, c0);
        exp_req(64'h3000, 1'b1, 64'h0123_4567_89AB_CDEF);
        exp_req(64'h3008, 1'b1, 64'hFEDC_BA98_7654_3210);
        exp_evt(E_DONE, c0 + 6);
        step(3);
        memReady_i = 1'b1;
        step(3);

        // illegal LQ: odd RT, then RT == RA, then reserved kind
        issue(2'd0, 5'd5, 1'b0, 5'd0, 12'h001, 64'h1000, 128'h0, c0);
        exp_evt(E_FAULT, c0 + 1);
        chk("fault_odd_noreq", memReq_o, 0);
        chk("fault_odd_stall", stall_o, 1);
        step(1);
        chk("fault_odd_idle", stall_o, 0);
        issue(2'd0, 5'd4, 1'b0, 5'd4, 12'h001, 64'h1000, 128'h0, c0);
        exp_evt(E_FAULT, c0 + 1);
        chk("fault_same_noreq", memReq_o, 0);
        step(1);
        issue(2'd3, 5'd2, 1'b0, 5'd0, 12'h000, 64'h1000, 128'h0, c0);
        exp_evt(E_FAULT, c0 + 1);
        step(1);

        // legal LQ RT=6 with delayed responses (cycles 3 and 5)
        issue(2'd0, 5'd6, 1'b1, 5'd1, 12'h002, 64'h4000, 128'h0, c0);
        exp_req(64'h4020, 1'b0, 64'h0);
        exp_req(64'h4028, 1'b0, 64'h0);
        exp_evt(E_WB, c0 + 6);
        exp_wb({64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002}, 6'd6, 1'b0);
        step(2);
        memRvalid_i = 1'b1; memRdata_i = 64'hDEAD_BEEF_0000_0001;
        step(1);
        memRvalid_i = 1'b0;
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'hCAFE_F00D_0000_0002;
        step(1);
        memRvalid_i = 1'b0;
        step(1);

        // address wrap-around
        issue(2'd2, 5'd0, 1'b0, 5'd0, 12'h001, 64'hFFFF_FFFF_FFFF_FFF0, {64'h1, 64'h2}, c0);
        exp_req(64'h0, 1'b1, 64'h1);
        exp_req(64'h8, 1'b1, 64'h2);
        exp_evt(E_DONE, c0 + 3);
        step(3);

        // misaligned quadword is issued as two doublewords when no alignment check is built in
        issue(2'd1, 5'd0, 1'b1, 5'd0, 12'h000, 64'h5004, 128'h0, c0);
        exp_req(64'h5004, 1'b0, 64'h0);
        exp_req(64'h500C, 1'b0, 64'h0);
        exp_evt(E_WB, c0 + 4);
        exp_wb({64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718}, 6'd32, 1'b1);
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'h0102_0304_0506_0708;
        step(1);
        memRdata_i = 64'h1112_1314_1516_1718;
        step(1);
        memRvalid_i = 1'b0;
        step(1);

        // reset in WAIT after one response: op dropped, stray response ignored
        issue(2'd1, 5'd2, 1'b0, 5'd0, 12'h000, 64'h6000, 128'h0, c0);
        exp_req(64'h6000, 1'b0, 64'h0);
        exp_req(64'h6008, 1'b0, 64'h0);
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'h0000_0000_0000_BAD1;
        step(1);
        memRvalid_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        check_zero("midreset");
        step(1);
        reset_n_i = 1'b1;
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'h0000_0000_0000_BAD2;
        step(1);
        memRvalid_i = 1'b0;
        chk("stray_idle", stall_o, 0);
        issue(2'd1, 5'd7, 1'b1, 5'd0, 12'h7FF, 64'h7000, 128'h0, c0);
        exp_req(64'hEFF0, 1'b0, 64'h0);
        exp_req(64'hEFF8, 1'b0, 64'h0);
        exp_evt(E_WB, c0 + 4);
        exp_wb({64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444}, 6'd39, 1'b1);
        step(1);
        memRvalid_i = 1'b1; memRdata_i = 64'h3333_3333_3333_3333;
        step(1);
        memRdata_i = 64'h4444_4444_4444_4444;
        step(1);
        memRvalid_i = 1'b0;
        step(3);

        chk("left_req", req_q.size(), 0);
        chk("left_evt", evt_q.size(), 0);
        chk("left_wb", wb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dq_lsu_sequencer.md
# dq_lsu_sequencer

Sequences decoded DQ-form quadword memory operations (Load Quadword, Load VSX Vector, Store VSX Vector) onto a 64-bit memory port. It sits between the DQ-form decoder and the load/store memory interface. Each accepted op is split into two doubleword beats, read data is collected into a 128-bit writeback, and the decoder is stalled while an op is in flight.

## Interface
Parameters:
- `regWidth`, 5: architected register index width.
- `immWidth`, 12: DQ immediate field width.
- `addrWidth`, 64: effective address width.
- `dataWidth`, 64: memory beat width. Writeback and store data are `2*dataWidth`.

Ports:
- `clock_i`, input, 1: single clock; all state changes on the rising edge.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `enable_i`, input, 1: decoded DQ op valid.
- `opKind_i`, input, 2: 0 = LQ, 1 = LXV, 2 = STXV, 3 = reserved (treated as illegal).
- `reg1_i`, input, regWidth: RT / XT / XS low bits.
- `bit_i`, input, 1: TX/SX bit. The VSR index is `{bit_i, reg1_i}`.
- `reg2_i`, input, regWidth: RA index, used only for the LQ legality check.
- `imm_i`, input, immWidth: DQ field.
- `baseAddr_i`, input, addrWidth: RA value. Upstream supplies 0 when RA = 0.
- `storeData_i`, input, 2*dataWidth: XS contents for STXV.
- `stall_o`, output, 1: high while busy.
- `memReq_o`, output, 1: memory request valid.
- `memReady_i`, input, 1: memory accepts the request.
- `memWe_o`, output, 1: 1 = store beat.
- `memAddr_o`, output, addrWidth: request address.
- `memWdata_o`, output, dataWidth: store beat data.
- `memRvalid_i`, input, 1: read response valid.
- `memRdata_i`, input, dataWidth: read response data.
- `wbEnable_o`, output, 1: one-cycle writeback strobe.
- `wbFile_o`, output, 1: 0 = GPR pair, 1 = VSR.
- `wbReg_o`, output, regWidth+1: destination register index.
- `wbData_o`, output, 2*dataWidth: beat0 in the high half, beat1 in the low half.
- `done_o`, output, 1: one-cycle op-complete pulse for both loads and stores.
- `fault_o`, output, 1: one-cycle illegal/alignment fault pulse.

## Operation
- **EA computation.** EA = `baseAddr_i` + sign-extended `{imm_i, 4'b0000}`, modulo 2^addrWidth (wrap-around is silent). Beat0 address is EA; beat1 address is EA+8, which also wraps.
- **Capture.** In IDLE with `enable_i`=1, the op is latched: kind, register indices, EA and store data.
- **Legality check.** The op is illegal if:
  - opKind = 3, or
  - it is LQ with odd RT, or
  - it is LQ with RT == RA.

  An illegal op goes to FAULT and issues no memory request.
- **States.** IDLE, REQ0, REQ1, WAIT, WB, DONE, FAULT.
  - IDLE → REQ0 on a legal accept; IDLE → FAULT on an illegal accept.
  - REQ0: `memReq_o`=1, address = EA. Stays in REQ0 until `memReady_i`=1, then → REQ1.
  - REQ1: address = EA+8. On accept, a store → DONE and a load → WAIT.
  - WAIT: stays until both read responses are captured, then → WB.
  - WB: `wbEnable_o`=1 and `done_o`=1, then → IDLE.
  - DONE: `done_o`=1, then → IDLE.
  - FAULT: `fault_o`=1, then → IDLE.
- **Read responses.**
  - Responses arrive in order, at least one cycle after their request is accepted.
  - A response can arrive in REQ1 or WAIT.
  - A 2-bit response counter tracks how many have arrived; the first response goes to the high half and the second to the low half.
  - A response is captured in the same cycle it arrives.
  - `memRvalid_i` in IDLE, DONE or FAULT is ignored.
- **Store data.** The high 64 bits of store data go out on beat0 and the low 64 bits on beat1.
- **Writeback target.**
  - LQ: `wbFile_o`=0, `wbReg_o`={0,RT}. RT receives beat0 and RT+1 receives beat1.
  - LXV: `wbFile_o`=1, `wbReg_o`={TX,T}.
- **Request stability.** While `memReq_o`=1 and `memReady_i`=0, the address, data and `memWe_o` are held stable.
- **Reset.** Assertion of `reset_n_i` at any point forces IDLE immediately. Every output returns to 0 and the counters clear. An in-flight op is dropped without writeback.

## Timing
- All outputs are registered.
- Reset value of every output is 0.
- `stall_o` is high in every state except IDLE, and goes high the cycle after an accept.
- `enable_i` is sampled only when `stall_o`=0.
- Store with `memReady_i` always 1:
  - accept at cycle 0
  - REQ0 in cycle 1
  - REQ1 in cycle 2
  - `done_o` in cycle 3
  - ready to accept again in cycle 4
- Load with `memReady_i` always 1 and zero-gap responses (responses in cycles 2 and 3): WB/`done_o` in cycle 4.
- Fault: `fault_o` in cycle 1, IDLE in cycle 2.
- Each cycle of `memReady_i`=0 adds one cycle of latency. Each cycle of response delay adds one cycle of latency.

## Configuration
- `DQ_SEQ_ALIGN_CHECK_EN`
  - **Defined:** an EA with bits [60:63] ≠ 0 (not 16-byte aligned) is treated as illegal. It goes to FAULT and issues no request.
  - **Not defined:** no alignment check. A misaligned quadword is issued as two doublewords at EA and EA+8.

## Structure
- Package `dq_seq_pkg` holds:
  - opKind localparams (OP_LQ, OP_LXV, OP_STXV)
  - the FSM state encoding
  - the beat offset constant (8)
  - the writeback file select values
- Sub-module `dq_ea_adder` (combinational) holds:
  - the immediate shift and sign-extension
  - the 64-bit add
  - the EA+8 computation
  - the alignment flag

## Test plan
- **STXV store.** Base 0x1000, imm 0x001, data 0xAAAA…_5555…, ready tied 1. Expect:
  - beats at 0x1010 / 0x1018 with data AAAA…, then 5555…
  - `done_o` in cycle 3
  - `stall_o` high in cycles 1–3
- **LXV load.** XT = {1,3}, base 0x2000, imm 0xFFF (−16). Expect:
  - requests to 0x1FF0 / 0x1FF8
  - responses 0x11…, 0x22… produce `wbData_o`={0x11…, 0x22…}
  - `wbReg_o`=35, `wbFile_o`=1
- **Back-pressure.** `memReady_i` low for 3 cycles during REQ0. Expect address and data held, and `done_o` delayed by 3 cycles.
- **Illegal LQ.** RT=5 (odd), or RT=RA=4. Expect `fault_o` pulse in cycle 1, no `memReq_o`, and no writeback.
- **Wrap-around.** Base 0xFFFF_FFFF_FFFF_FFF0, imm 0x001. Expect beat addresses 0x0 and 0x8.
- **Reset mid-op.** Assert `reset_n_i` in WAIT after one response, then release. Expect:
  - all outputs 0 immediately
  - no writeback
  - a stray `memRvalid_i` afterwards is ignored
  - the next op completes normally
